// File: rtl/ntt_mdc_ctrl_if.sv
// Handshake and stage-control bundle between the NTT MDC sequencer and its neighbours.
// The slave side is the controller; the master side is the command source plus the stage chain.
interface ntt_mdc_ctrl_if #(
    parameter int LOGQ = 64
);
    logic            cmd_valid;
    logic            cmd_intt;
    logic [LOGQ-1:0] cmd_q;
    logic            cmd_ready;
    logic            in_valid;
    logic            in_ready;
    logic            stage_start;
    logic            stage_intt;
    logic [LOGQ-1:0] stage_q;
    logic            chain_finish;
    logic            out_valid;
    logic            out_last;
    logic            done;
    logic            busy;
    logic            err;

    modport master (
        output cmd_valid, cmd_intt, cmd_q, in_valid, chain_finish,
        input  cmd_ready, in_ready, stage_start, stage_intt, stage_q,
        input  out_valid, out_last, done, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_intt, cmd_q, in_valid, chain_finish,
        output cmd_ready, in_ready, stage_start, stage_intt, stage_q,
        output out_valid, out_last, done, busy, err
    );
endinterface

// File: rtl/ntt_mdc_ctrl.sv
// Sequencer in front of the ntt_mdc_stage chain. Accepts one command per polynomial, opens a
// gap-free load window of HALF beats, and counts result beats coming back from the last stage.
// The chain cannot be stalled, so any gap in a load or a stray result beat locks the controller
// in ERR until reset.
module ntt_mdc_ctrl #(
    parameter int LOGN         = 10,
    parameter int LOGQ         = 64,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    ntt_mdc_ctrl_if.slave     bus
);

    localparam int CW   = LOGN - 1;
    localparam int HALF = 2 ** (LOGN - 1);
    localparam int IW   = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(HALF - 1);
    localparam logic [IW-1:0] MAX_IF    = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic            stage_intt_q, stage_intt_d;
    logic [LOGQ-1:0] stage_q_q, stage_q_d;

    logic cmd_ready_c;
    logic in_ready_c;
    logic stage_start_c;
    logic out_last_c;
    logic inc_c;
    logic dec_c;

    // Register update; a synchronous reset discards any polynomial in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            out_cnt_q    <= '0;
            inflight_q   <= '0;
            stage_intt_q <= 1'b0;
            stage_q_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            out_cnt_q    <= out_cnt_d;
            inflight_q   <= inflight_d;
            stage_intt_q <= stage_intt_d;
            stage_q_q    <= stage_q_d;
        end
    end

    // Next-state, command acceptance, load window and result-beat bookkeeping.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        out_cnt_d     = out_cnt_q;
        inflight_d    = inflight_q;
        stage_intt_d  = stage_intt_q;
        stage_q_d     = stage_q_q;
        cmd_ready_c   = 1'b0;
        in_ready_c    = 1'b0;
        stage_start_c = 1'b0;
        inc_c         = 1'b0;

        out_last_c = bus.chain_finish && (out_cnt_q == LAST_BEAT);
        dec_c      = out_last_c && (inflight_q != '0);

        if (bus.chain_finish) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                cmd_ready_c = (inflight_q == '0);
                if (bus.cmd_valid && cmd_ready_c) begin
                    state_d      = LOAD;
                    stage_intt_d = bus.cmd_intt;
                    stage_q_d    = bus.cmd_q;
                    beat_cnt_d   = '0;
                    inc_c        = 1'b1;
                end
            end
            LOAD: begin
                in_ready_c    = 1'b1;
                stage_start_c = bus.in_valid;
                if (!bus.in_valid) begin
                    state_d = ERR;
                end else if (beat_cnt_q == LAST_BEAT) begin
                    cmd_ready_c = (bus.cmd_intt == stage_intt_q) &&
                                  (bus.cmd_q == stage_q_q) &&
                                  (inflight_q < MAX_IF);
                    if (bus.cmd_valid && cmd_ready_c) begin
                        beat_cnt_d = '0;
                        inc_c      = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase

        if (bus.chain_finish && (inflight_q == '0)) begin
            state_d = ERR;
        end

        case ({inc_c, dec_c})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    assign bus.cmd_ready   = !rst && cmd_ready_c;
    assign bus.in_ready    = !rst && in_ready_c;
    assign bus.stage_start = !rst && stage_start_c;
    assign bus.stage_intt  = !rst && stage_intt_q;
    assign bus.stage_q     = rst ? '0 : stage_q_q;
    assign bus.out_valid   = !rst && bus.chain_finish;
    assign bus.out_last    = !rst && out_last_c;
    assign bus.done        = !rst && out_last_c;
    assign bus.busy        = !rst && ((state_q != IDLE) || (inflight_q != '0));
    assign bus.err         = !rst && (state_q == ERR);

endmodule
